// File: rtl/rlgl_referee.sv
// rlgl_referee - game referee for Red Light, Green Light.
//
// Sits downstream of the traffic light. Counts player steps toward a finish
// line, penalises steps taken during red once the reaction grace window has
// run out, runs the game countdown and declares win/lose. game_active goes
// back to the traffic light, which freezes while it is low.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset        synchronous, active-high
//   start        level; rising edge starts a game (ignored while playing)
//   step         level; rising edge is one player step
//   red, green   current light from the traffic light
//   game_active  high only while a game is in progress
//   position     steps taken, 0..FINISH
//   time_left    seconds remaining
//   lives        remaining lives
//   win, lose    game outcome, held until the next start
//
// Build option: define RLGL_LIVES_EN for three lives per game; a red-light
// violation then costs a life and sends the player back to the start line.
// Without it a single violation loses the game and lives stays at 1.
//
// state | meaning
// IDLE  | after reset, waiting for start
// PLAY  | game running
// WIN   | player reached FINISH, outputs frozen
// LOSE  | violation or timeout, outputs frozen
module rlgl_referee #(
  parameter int FINISH    = 20,
  parameter int GRACE_CYC = 25_000_000,
  parameter int SECOND    = 50_000_000,
  parameter int GAME_SEC  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  input  logic       red,
  input  logic       green,
  output logic       game_active,
  output logic [4:0] position,
  output logic [5:0] time_left,
  output logic [1:0] lives,
  output logic       win,
  output logic       lose
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] WIN  = 2'd2;
  localparam logic [1:0] LOSE = 2'd3;

  localparam int GW = (GRACE_CYC > 0) ? $clog2(GRACE_CYC + 1) : 1;
  localparam int SW = (SECOND > 1) ? $clog2(SECOND) : 1;

  localparam logic [GW-1:0] GRACE_LOAD = GW'(GRACE_CYC);
  localparam logic [GW-1:0] GRACE_ONE  = GW'(1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(SECOND - 1);
  localparam logic [SW-1:0] SEC_ONE    = SW'(1);
  localparam logic [4:0]    FIN        = 5'(FINISH);
  localparam logic [5:0]    TIME_INIT  = 6'(GAME_SEC);
`ifdef RLGL_LIVES_EN
  localparam logic [1:0]    LIVES_INIT = 2'd3;
`else
  localparam logic [1:0]    LIVES_INIT = 2'd1;
`endif

  logic [1:0]    state_q, state_d;
  logic [4:0]    position_q, position_d;
  logic [5:0]    time_left_q, time_left_d;
  logic [1:0]    lives_q, lives_d;
  logic [GW-1:0] grace_q, grace_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          start_q, step_q, red_q;

  logic       start_p, step_p, red_rise;
  logic       violation;
  logic [4:0] pos_inc;

  assign start_p  = start & ~start_q;
  assign step_p   = step & ~step_q;
  assign red_rise = red & ~red_q;

  // green wins if both lights are (illegally) on; no light at all ignores the step
  assign violation = step_p & ~green & red & (grace_q == '0);
  assign pos_inc   = (position_q == FIN) ? FIN : position_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    position_d  = position_q;
    time_left_d = time_left_q;
    lives_d     = lives_q;
    grace_d     = grace_q;
    sec_d       = sec_q;

    if (state_q == PLAY) begin
      if (red_rise)
        grace_d = GRACE_LOAD;
      else if (grace_q != '0)
        grace_d = grace_q - GRACE_ONE;

      if (sec_q == SEC_LAST) begin
        sec_d = '0;
        if (time_left_q != 6'd0)
          time_left_d = time_left_q - 6'd1;
      end else begin
        sec_d = sec_q + SEC_ONE;
      end

      if (step_p && green) begin
        position_d = pos_inc;
        if (pos_inc == FIN)
          state_d = WIN;
      end else if (violation) begin
`ifdef RLGL_LIVES_EN
        if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = LOSE;
        end else begin
          lives_d    = lives_q - 2'd1;
          position_d = 5'd0;
        end
`else
        state_d = LOSE;
`endif
      end

      // expiry is lowest priority: only applies if nothing above ended the game
      if (state_d == PLAY && time_left_q == 6'd0)
        state_d = LOSE;
    end else if (start_p) begin
      state_d     = PLAY;
      position_d  = 5'd0;
      time_left_d = TIME_INIT;
      lives_d     = LIVES_INIT;
      grace_d     = '0;
      sec_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      position_q  <= 5'd0;
      time_left_q <= TIME_INIT;
      lives_q     <= LIVES_INIT;
      grace_q     <= '0;
      sec_q       <= '0;
      start_q     <= 1'b0;
      step_q      <= 1'b0;
      red_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      position_q  <= position_d;
      time_left_q <= time_left_d;
      lives_q     <= lives_d;
      grace_q     <= grace_d;
      sec_q       <= sec_d;
      start_q     <= start;
      step_q      <= step;
      red_q       <= red;
    end
  end

  assign game_active = (state_q == PLAY);
  assign win         = (state_q == WIN);
  assign lose        = (state_q == LOSE);
  assign position    = position_q;
  assign time_left   = time_left_q;
  assign lives       = lives_q;

endmodule

// File: tb/tb_rlgl_referee.sv
module tb_rlgl_referee;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic       red = 1'b0;
  logic       green = 1'b0;
  logic       game_active;
  logic [4:0] position;
  logic [5:0] time_left;
  logic [1:0] lives;
  logic       win;
  logic       lose;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RLGL_LIVES_EN
  localparam logic [1:0] LIVES0 = 2'd3;
`else
  localparam logic [1:0] LIVES0 = 2'd1;
`endif

  rlgl_referee #(
    .FINISH(3), .GRACE_CYC(4), .SECOND(10), .GAME_SEC(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .red(red), .green(green), .game_active(game_active),
    .position(position), .time_left(time_left), .lives(lives),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // advance one active edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle step pulse followed by a low cycle; effect visible on return
  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL rst_active got %0d want 0", game_active); end
    n_checks++; if (position !== 5'd0) begin n_fail++; $display("FAIL rst_position got %0d want 0", position); end
    n_checks++; if (time_left !== 6'd5) begin n_fail++; $display("FAIL rst_time got %0d want 5", time_left); end
    n_checks++; if (lives !== LIVES0) begin n_fail++; $display("FAIL rst_lives got %0d want %0d", lives, LIVES0); end
    n_checks++; if (win !== 1'b0 || lose !== 1'b0) begin n_fail++; $display("FAIL rst_outcome got win=%0d lose=%0d want 0/0", win, lose); end
  endtask

  task automatic test_timeout();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (game_active !== 1'b1) begin n_fail++; $display("FAIL to_start_active got %0d want 1", game_active); end
    n_checks++; if (time_left !== 6'd5) begin n_fail++; $display("FAIL to_start_time got %0d want 5", time_left); end
    repeat (49) tick();
    n_checks++; if (time_left !== 6'd1) begin n_fail++; $display("FAIL to_time49 got %0d want 1", time_left); end
    tick();
    n_checks++; if (time_left !== 6'd0) begin n_fail++; $display("FAIL to_time50 got %0d want 0", time_left); end
    n_checks++; if (game_active !== 1'b1 || lose !== 1'b0) begin n_fail++; $display("FAIL to_still_play got active=%0d lose=%0d want 1/0", game_active, lose); end
    tick();
    n_checks++; if (lose !== 1'b1 || game_active !== 1'b0) begin n_fail++; $display("FAIL to_lose got lose=%0d active=%0d want 1/0", lose, game_active); end
  endtask

  task automatic test_win();
    red = 1'b0;
    green = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (game_active !== 1'b1 || time_left !== 6'd5 || position !== 5'd0) begin n_fail++; $display("FAIL win_restart got active=%0d time=%0d pos=%0d want 1/5/0", game_active, time_left, position); end
    pulse_step();
    n_checks++; if (position !== 5'd1) begin n_fail++; $display("FAIL win_pos1 got %0d want 1", position); end
    pulse_step();
    n_checks++; if (position !== 5'd2 || win !== 1'b0) begin n_fail++; $display("FAIL win_pos2 got pos=%0d win=%0d want 2/0", position, win); end
    pulse_step();
    n_checks++; if (position !== 5'd3 || win !== 1'b1 || game_active !== 1'b0 || lose !== 1'b0) begin n_fail++; $display("FAIL win_pos3 got pos=%0d win=%0d active=%0d lose=%0d want 3/1/0/0", position, win, game_active, lose); end
    pulse_step();
    red = 1'b1;
    green = 1'b0;
    tick();
    pulse_step();
    n_checks++; if (position !== 5'd3 || win !== 1'b1 || lose !== 1'b0) begin n_fail++; $display("FAIL win_frozen got pos=%0d win=%0d lose=%0d want 3/1/0", position, win, lose); end
  endtask

  task automatic test_grace_violation();
    red = 1'b0;
    green = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_step();
    pulse_step();
    n_checks++; if (position !== 5'd2 || game_active !== 1'b1) begin n_fail++; $display("FAIL gv_setup got pos=%0d active=%0d want 2/1", position, game_active); end
    red = 1'b1;
    green = 1'b0;
    tick();                      // red rise sampled here
    tick();
    step = 1'b1;
    tick();                      // step 2 cycles after the rise
    step = 1'b0;
    n_checks++; if (position !== 5'd2 || lose !== 1'b0 || game_active !== 1'b1) begin n_fail++; $display("FAIL gv_grace2 got pos=%0d lose=%0d active=%0d want 2/0/1", position, lose, game_active); end
    tick();
    step = 1'b1;
    tick();                      // last cycle of the window
    step = 1'b0;
    n_checks++; if (position !== 5'd2 || lose !== 1'b0 || game_active !== 1'b1) begin n_fail++; $display("FAIL gv_grace4 got pos=%0d lose=%0d active=%0d want 2/0/1", position, lose, game_active); end
    tick();
    step = 1'b1;
    tick();                      // 6 cycles after the rise: window expired
    step = 1'b0;
`ifdef RLGL_LIVES_EN
    n_checks++; if (lives !== 2'd2 || position !== 5'd0 || game_active !== 1'b1 || lose !== 1'b0) begin n_fail++; $display("FAIL gv_life1 got lives=%0d pos=%0d active=%0d lose=%0d want 2/0/1/0", lives, position, game_active, lose); end
    tick();
    pulse_step();
    n_checks++; if (lives !== 2'd1 || position !== 5'd0 || game_active !== 1'b1) begin n_fail++; $display("FAIL gv_life2 got lives=%0d pos=%0d active=%0d want 1/0/1", lives, position, game_active); end
    pulse_step();
    n_checks++; if (lives !== 2'd0 || lose !== 1'b1 || game_active !== 1'b0) begin n_fail++; $display("FAIL gv_life3 got lives=%0d lose=%0d active=%0d want 0/1/0", lives, lose, game_active); end
`else
    n_checks++; if (lose !== 1'b1 || game_active !== 1'b0) begin n_fail++; $display("FAIL gv_lose got lose=%0d active=%0d want 1/0", lose, game_active); end
    n_checks++; if (position !== 5'd2 || lives !== 2'd1) begin n_fail++; $display("FAIL gv_hold got pos=%0d lives=%0d want 2/1", position, lives); end
`endif
  endtask

  task automatic test_win_vs_timeout();
    red = 1'b0;
    green = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_step();
    pulse_step();
    n_checks++; if (position !== 5'd2) begin n_fail++; $display("FAIL wt_setup got %0d want 2", position); end
    repeat (46) tick();
    n_checks++; if (time_left !== 6'd0 || game_active !== 1'b1 || lose !== 1'b0) begin n_fail++; $display("FAIL wt_zero got time=%0d active=%0d lose=%0d want 0/1/0", time_left, game_active, lose); end
    step = 1'b1;
    tick();                      // winning step collides with expiry
    step = 1'b0;
    n_checks++; if (win !== 1'b1 || lose !== 1'b0 || position !== 5'd3) begin n_fail++; $display("FAIL wt_win got win=%0d lose=%0d pos=%0d want 1/0/3", win, lose, position); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    pulse_step();
    pulse_step();
    n_checks++; if (position !== 5'd2 || game_active !== 1'b1) begin n_fail++; $display("FAIL rm_setup got pos=%0d active=%0d want 2/1", position, game_active); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (game_active !== 1'b0 || position !== 5'd0 || time_left !== 6'd5) begin n_fail++; $display("FAIL rm_abort got active=%0d pos=%0d time=%0d want 0/0/5", game_active, position, time_left); end
    n_checks++; if (win !== 1'b0 || lose !== 1'b0 || lives !== LIVES0) begin n_fail++; $display("FAIL rm_outcome got win=%0d lose=%0d lives=%0d want 0/0/%0d", win, lose, lives, LIVES0); end
    tick();
    n_checks++; if (game_active !== 1'b0) begin n_fail++; $display("FAIL rm_idle got %0d want 0", game_active); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (game_active !== 1'b1 || time_left !== 6'd5 || position !== 5'd0) begin n_fail++; $display("FAIL rm_rearm got active=%0d time=%0d pos=%0d want 1/5/0", game_active, time_left, position); end
    red = 1'b0;
    green = 1'b0;
    pulse_step();
    n_checks++; if (position !== 5'd0 || lose !== 1'b0 || game_active !== 1'b1) begin n_fail++; $display("FAIL rm_nolight got pos=%0d lose=%0d active=%0d want 0/0/1", position, lose, game_active); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_win();
    test_grace_violation();
    test_win_vs_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rlgl_referee.md
Name: rlgl_referee

Overview:
- Game referee stage directly downstream of the traffic light in the Red Light, Green Light design.
- Consumes the light's red/green outputs and the player's step button, and tracks the player's position toward a finish line.
- Penalises steps taken during red, after a reaction grace window has expired.
- Runs the overall game countdown, declares win/lose, and drives game_active back to the traffic light, which freezes whenever game_active is low.

Parameters:
- FINISH, 20: steps required to win; 1..31.
- GRACE_CYC, 25_000_000: clock cycles after red onset during which steps are ignored (0.5 s at 50 MHz).
- SECOND, 50_000_000: clock cycles per second for the game timer.
- GAME_SEC, 60: game length in seconds; 1..63.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- start  in  1  level, already synchronised/debounced; rising edge starts a game
- step  in  1  level, already synchronised/debounced; rising edge = one player step
- red  in  1  from traffic light
- green  in  1  from traffic light
- game_active  out  1  high only in PLAY
- position  out  5  steps taken, 0..FINISH
- time_left  out  6  seconds remaining
- lives  out  2  remaining lives
- win  out  1  high in WIN state
- lose  out  1  high in LOSE state

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high.
- Reset values:
  - State: IDLE.
  - position=0, time_left=GAME_SEC, game_active=0, win=0, lose=0.
  - lives=1, or 3 with LIVES_EN.
  - Grace counter, second counter and edge registers are all 0.
  - Reset mid-game aborts immediately to these values.
- Edge detect: registered copies start_q, step_q and red_q.
  - start_p = start & ~start_q
  - step_p = step & ~step_q
  - red_rise = red & ~red_q
  - The red_q register updates in every state, so red_rise is a one-cycle pulse.
- States and transitions:
  - IDLE: outputs hold. start_p -> PLAY.
  - Entering PLAY: position=0, time_left=GAME_SEC, second counter=0, grace=0, lives restored to their reset value.
  - WIN/LOSE: outputs frozen. start_p -> PLAY with the same initialisation as above.
  - game_active = (state==PLAY), registered with the state; visible the cycle after the transition.
- Grace window (PLAY only):
  - red_rise loads grace with GRACE_CYC.
  - Otherwise grace decrements by 1 per cycle while nonzero.
  - red_rise while grace is nonzero reloads grace.
- Step handling (PLAY only), evaluated on step_p:
  - green=1: position+1. If the new value == FINISH -> WIN next cycle; position saturates at FINISH.
  - red=1 and grace!=0: step ignored; no advance, no penalty.
  - red=1 and grace==0: violation -> LOSE next cycle; position unchanged.
  - red=green=0 (only possible on invalid input): step ignored.
- Game timer (PLAY only):
  - The second counter counts 0..SECOND-1; on wrap, time_left decrements.
  - time_left==0 while in PLAY -> LOSE.
- Simultaneous events, priority highest first:
  1. reset
  2. winning step
  3. violation
  4. timer expiry

  A winning step on the same cycle time_left reaches 0 yields WIN.
- start_p while in PLAY is ignored.
- Latency: a step edge affects position/win/lose one clock after step rises plus one register (step_p is combinational from step_q), i.e. 1 cycle after the sampled rising edge.

Optional Feature:
- Macro: RLGL_LIVES_EN.
- Defined:
  - lives initialises to 3 on entry to PLAY.
  - A violation decrements lives and resets position to 0; the game stays in PLAY. Grace is not reloaded.
  - A violation with lives==1 sets lives=0 and goes to LOSE.
- Undefined:
  - lives is constant 1; any violation goes straight to LOSE with lives unchanged.

Test Plan (overrides SECOND=10, GRACE_CYC=4, FINISH=3, GAME_SEC=5):
1. Reset then start pulse -> game_active=1 next cycle, position=0, time_left=5; with no steps, time_left reaches 0 after 50 cycles -> lose=1, game_active=0.
2. green=1, three step pulses -> position 1,2,3; win=1 the cycle after the third step; further steps and red changes leave position=3.
3. red rises, step pulse 2 cycles later -> ignored (position unchanged, lose=0); step pulse 6 cycles after the red rise -> lose=1 (without LIVES_EN).
4. Winning third step on the same cycle time_left hits 0 -> win=1, lose=0.
5. reset asserted mid-PLAY with position=2 -> next cycle IDLE, position=0, game_active=0; a subsequent start pulse re-arms with time_left=5.
6. With RLGL_LIVES_EN: violation at position=2 -> lives=2, position=0, still PLAY; two more violations -> lives=0, lose=1.
